uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command-side controller at the far end of the UART link: consumes received bytes from the UART receiver and parses command frames. Executes register-file writes and reads. Returns read data to the UART transmitter using its valid/busy handshake. Sits between uart_top and the register file in the single-clock system domain.

Parameters:
ADDR_WIDTH, 4, register-file address width; the address byte uses its low ADDR_WIDTH bits.
DATA_WIDTH, 8, register data width; fixed at 8 to match UART byte width.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_p_data  input  8  received byte
rx_data_valid  input  1  one-cycle pulse, rx_p_data valid (already synchronised to clk)
tx_p_data  output  8  byte to transmit
tx_data_valid  output  1  transmit request, held until accepted
busy  input  1  transmitter busy (synchronised to clk)
rf_addr  output  ADDR_WIDTH  register-file address
rf_wr_data  output  8  register write data
rf_wr_en  output  1  one-cycle write strobe
rf_rd_en  output  1  one-cycle read strobe
rf_rd_data  input  8  read data
rf_rd_valid  input  1  read data valid pulse
frame_err  output  1  one-cycle pulse on dropped/illegal byte

Behaviour:
- Reset (async, rst=1): state=IDLE; tx_p_data=0, tx_data_valid=0, rf_addr=0, rf_wr_data=0, rf_wr_en=0, rf_rd_en=0, frame_err=0. All outputs registered.
- Frames: write = 0xAA, addr, data; read = 0xBB, addr. One byte consumed per rx_data_valid pulse.
- States:
  - IDLE: on rx byte 0xAA go to WR_ADDR; on 0xBB go to RD_ADDR; any other byte pulses frame_err and stays in IDLE.
  - WR_ADDR: on rx byte, latch rf_addr = byte[ADDR_WIDTH-1:0] and go to WR_DATA.
  - WR_DATA: on rx byte, rf_wr_data = byte; rf_wr_en=1 the next cycle (exactly one cycle); go to IDLE.
  - RD_ADDR: on rx byte, latch rf_addr; rf_rd_en=1 the next cycle (one cycle); go to RD_WAIT.
  - RD_WAIT: wait for rf_rd_valid. On it, tx_p_data = rf_rd_data and go to TX_REQ. rf_rd_valid in the same cycle as rf_rd_en is legal.
  - TX_REQ: tx_data_valid=1, tx_p_data stable. When busy=1 is sampled, deassert tx_data_valid and go to TX_WAIT.
  - TX_WAIT: when busy=0, go to IDLE.
- Latency: write strobe 1 cycle after the data byte's rx_data_valid. Read strobe 1 cycle after the addr byte's rx_data_valid. tx_data_valid rises 1 cycle after rf_rd_valid.
- Bytes arriving in RD_WAIT, TX_REQ or TX_WAIT: dropped, frame_err pulses 1 cycle, state unchanged.
- Address byte wider than ADDR_WIDTH: upper bits ignored, no error.
- rf_addr holds its last value between operations.
- rf_wr_en and rf_rd_en are never asserted together.
- frame_err does not coincide with any rf strobe caused by the same byte.
- busy already high on entry to TX_REQ: tx_data_valid asserts for exactly 1 cycle, then TX_WAIT.
- Reset mid-frame or mid-handshake: immediate return to IDLE, all strobes and tx_data_valid drop asynchronously; the partial frame is discarded.

Test Plan:
- Write: rx 0xAA, 0x05, 0x3C → rf_wr_en single pulse with rf_addr=5, rf_wr_data=0x3C, 1 cycle after the third byte; no frame_err.
- Read: rx 0xBB, 0x13; rf_rd_valid with rf_rd_data=0x7E 2 cycles after rf_rd_en → rf_addr=3, rf_rd_en one pulse. Then tx_data_valid=1 with tx_p_data=0x7E until busy=1, then deasserts. State returns to IDLE after busy falls.
- Illegal command: rx 0x11 → frame_err 1-cycle pulse, no rf strobes. Following 0xAA,0x02,0x09 still writes addr 2 = 0x09.
- Byte during transmit: read 0xBB,0x01, then rx 0xCC while busy=1 → frame_err pulse, 0xCC not parsed. Next frame 0xAA,0x04,0x55 executes normally.
- Back-to-back rx pulses on consecutive cycles: 0xAA,0x0F,0xFF → write addr 0xF = 0xFF.
- Reset asserted in TX_REQ and in WR_DATA → tx_data_valid/rf_wr_en 0 immediately, state IDLE. A new frame after reset release parses from its first byte.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses command frames from the UART receiver, drives
// register-file write/read strobes and returns read data to the UART
// transmitter through its valid/busy handshake.
//
// Frames: write = 0xAA, addr, data ; read = 0xBB, addr
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command byte (0xAA / 0xBB), others are errors
// WR_ADDR | write command seen, next byte is the register address
// WR_DATA | address latched, next byte is the write data
// RD_ADDR | read command seen, next byte is the register address
// RD_WAIT | read strobe issued, waiting for rf_rd_valid
// TX_REQ  | tx_data_valid held until the transmitter reports busy
// TX_WAIT | transmitter busy, waiting for it to go idle
module uart_cmd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_p_data,
  input  logic                  rx_data_valid,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  input  logic                  busy,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  frame_err
);

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_REQ  = 3'd5,
    TX_WAIT = 3'd6
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wr_data_q;
  logic                  rf_wr_en_q;
  logic                  rf_rd_en_q;
  logic                  frame_err_q;

  // Frame parser and handshake FSM; every output is a register of this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // strobes are single-cycle unless re-armed below
      rf_wr_en_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rx_data_valid) begin
            if (rx_p_data == CMD_WR) begin
              state_q <= WR_ADDR;
            end else if (rx_p_data == CMD_RD) begin
              state_q <= RD_ADDR;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        WR_ADDR: begin
          if (rx_data_valid) begin
            // upper address bits beyond the register file are ignored
            rf_addr_q <= rx_p_data[ADDR_WIDTH-1:0];
            state_q   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (rx_data_valid) begin
            rf_wr_data_q <= rx_p_data[DATA_WIDTH-1:0];
            rf_wr_en_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end

        RD_ADDR: begin
          if (rx_data_valid) begin
            rf_addr_q  <= rx_p_data[ADDR_WIDTH-1:0];
            rf_rd_en_q <= 1'b1;
            state_q    <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // read data may return in the same cycle as the read strobe
          if (rx_data_valid) begin
            frame_err_q <= 1'b1;
          end
          if (rf_rd_valid) begin
            tx_data_q  <= rf_rd_data;
            tx_valid_q <= 1'b1;
            state_q    <= TX_REQ;
          end
        end

        TX_REQ: begin
          if (rx_data_valid) begin
            frame_err_q <= 1'b1;
          end
          // busy already high on entry still gives one cycle of valid
          if (busy) begin
            tx_valid_q <= 1'b0;
            state_q    <= TX_WAIT;
          end
        end

        TX_WAIT: begin
          if (rx_data_valid) begin
            frame_err_q <= 1'b1;
          end
          if (!busy) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_p_data     = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign rf_addr       = rf_addr_q;
  assign rf_wr_data    = rf_wr_data_q;
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_rd_en      = rf_rd_en_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames, a register-file responder and a
// transmitter model, with scoreboard queues for writes, reads and tx bytes.
module tb_uart_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_p_data;
  logic       rx_data_valid;
  logic [7:0] tx_p_data;
  logic       tx_data_valid;
  logic       busy;
  logic       busy_m;
  logic       busy_f;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          exp_err = 0;

  logic [7:0] model_mem[16];
  logic [7:0] rf_mem[16];

  int   rd_delay = 2;
  int   tx_lat   = 1;
  int   busy_len = 4;
  logic tx_en    = 1'b1;
  logic tx_active = 1'b0;
  logic prev_wr  = 1'b0;
  logic prev_rd  = 1'b0;

  assign busy = busy_m | busy_f;

  uart_cmd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .busy          (busy),
    .rf_addr       (rf_addr),
    .rf_wr_data    (rf_wr_data),
    .rf_wr_en      (rf_wr_en),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_data    (rf_rd_data),
    .rf_rd_valid   (rf_rd_valid),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // all stimulus tasks are entered at a negedge and return at a negedge
  task automatic send(input logic [7:0] b);
    rx_p_data     = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
    model_mem[a[3:0]] = d;
    exp_wr.push_back({a[3:0], d});
    send(8'hAA);
    idle(gap);
    send(a);
    idle(gap);
    send(d);
    chk("wr_latency", rf_wr_en, 1'b1);
    @(negedge clk);
    chk("wr_single", rf_wr_en, 1'b0);
  endtask

  task automatic read_frame(input logic [7:0] a, input logic push_tx);
    exp_rd.push_back(a[3:0]);
    if (push_tx) exp_tx.push_back(model_mem[a[3:0]]);
    send(8'hBB);
    send(a);
    chk("rd_latency", rf_rd_en, 1'b1);
    @(negedge clk);
    chk("rd_single", rf_rd_en, 1'b0);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_err++;
    send(b);
    chk("err_latency", frame_err, 1'b1);
  endtask

  task automatic wait_tx_done(input int budget);
    int n = 0;
    while (!(exp_tx.size() == 0 && !tx_active && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_done_timeout", n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_tx_valid(input int budget);
    int n = 0;
    while (!tx_data_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_valid_timeout", n < budget, 1'b1);
  endtask

  // scoreboard monitor: register-file strobes and frame errors
  always @(negedge clk) begin
    if (rf_wr_en && rf_rd_en) chk("wr_rd_exclusive", 1'b1, 1'b0);
    if (rf_wr_en && prev_wr) chk("wr_width", 1'b1, 1'b0);
    if (rf_rd_en && prev_rd) chk("rd_width", 1'b1, 1'b0);
    if (rf_wr_en) begin
      rf_mem[rf_addr] = rf_wr_data;
      if (exp_wr.size() == 0) chk("wr_unexpected", 1'b1, 1'b0);
      else chk("wr_addr_data", {rf_addr, rf_wr_data}, exp_wr.pop_front());
    end
    if (rf_rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1'b1, 1'b0);
      else chk("rd_addr", rf_addr, exp_rd.pop_front());
    end
    if (frame_err) begin
      if (exp_err == 0) chk("err_unexpected", 1'b1, 1'b0);
      else exp_err--;
    end
    prev_wr = rf_wr_en;
    prev_rd = rf_rd_en;
  end

  // register-file read responder
  initial begin
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rf_rd_en && !rst) begin
        logic [7:0] d;
        d = rf_mem[rf_addr];
        repeat (rd_delay) @(negedge clk);
        rf_rd_data  = d;
        rf_rd_valid = 1'b1;
        @(negedge clk);
        rf_rd_valid = 1'b0;
      end
    end
  end

  // transmitter model: accepts after tx_lat cycles, then stays busy
  initial begin
    busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && tx_data_valid) begin
        tx_active = 1'b1;
        if (exp_tx.size() == 0) chk("tx_unexpected", 1'b1, 1'b0);
        else chk("tx_data", tx_p_data, exp_tx.pop_front());
        repeat (tx_lat) @(negedge clk);
        chk("tx_hold", tx_data_valid, 1'b1);
        busy_m = 1'b1;
        @(negedge clk);
        chk("tx_drop", tx_data_valid, 1'b0);
        repeat (busy_len) @(negedge clk);
        busy_m = 1'b0;
        tx_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'h00;
      rf_mem[i]    = 8'h00;
    end
    rst = 1'b1;
    rx_p_data = 8'h00;
    rx_data_valid = 1'b0;
    busy_f = 1'b0;
    #1;
    chk("rst_tx_valid", tx_data_valid, 1'b0);
    chk("rst_tx_data", tx_p_data, 8'h00);
    chk("rst_rf_addr", rf_addr, 4'h0);
    chk("rst_wr_data", rf_wr_data, 8'h00);
    chk("rst_strobes", {rf_wr_en, rf_rd_en, frame_err}, 3'b000);
    idle(2);
    rst = 1'b0;
    @(negedge clk);

    // basic writes, gapped and back-to-back, upper address bits ignored
    write_frame(8'h05, 8'h3C, 1);
    chk("addr_hold", rf_addr, 4'h5);
    write_frame(8'h23, 8'h7E, 0);
    write_frame(8'h01, 8'hA5, 2);

    // read with data returned two cycles after the strobe
    rd_delay = 2;
    read_frame(8'h13, 1'b1);
    wait_tx_done(60);

    // illegal command then a normal write
    send_bad(8'h11);
    idle(1);
    write_frame(8'h02, 8'h09, 0);

    // same-cycle read data; byte arriving while the transmitter is busy
    rd_delay = 0;
    read_frame(8'h01, 1'b1);
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", n < 40, 1'b1);
    send_bad(8'hCC);
    wait_tx_done(60);
    write_frame(8'h04, 8'h55, 1);

    // back-to-back frame to the top address, byte dropped in RD_WAIT
    write_frame(8'h0F, 8'hFF, 0);
    rd_delay = 3;
    read_frame(8'h0F, 1'b1);
    send_bad(8'hDD);
    wait_tx_done(60);

    // busy already high when the request starts: one-cycle valid
    tx_en  = 1'b0;
    busy_f = 1'b1;
    rd_delay = 1;
    read_frame(8'h02, 1'b0);
    wait_tx_valid(20);
    chk("prebusy_data", tx_p_data, 8'h09);
    @(negedge clk);
    chk("prebusy_one_cycle", tx_data_valid, 1'b0);
    busy_f = 1'b0;
    idle(2);

    // reset while holding a transmit request
    read_frame(8'h04, 1'b0);
    wait_tx_valid(20);
    #2 rst = 1'b1;
    #1;
    chk("rst_txreq_valid", tx_data_valid, 1'b0);
    chk("rst_txreq_data", tx_p_data, 8'h00);
    chk("rst_txreq_addr", rf_addr, 4'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    tx_en = 1'b1;
    write_frame(8'h06, 8'h66, 0);

    // reset mid write frame: the pending data byte is now an illegal command
    send(8'hAA);
    send(8'h0A);
    #2 rst = 1'b1;
    #1;
    chk("rst_wrdata_addr", rf_addr, 4'h0);
    chk("rst_wrdata_wr_en", rf_wr_en, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send_bad(8'h3C);
    idle(1);
    rd_delay = 2;
    read_frame(8'h06, 1'b1);
    wait_tx_done(60);
    chk("rf_mem_5", rf_mem[5], 8'h3C);

    n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 || exp_err != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("left_wr", exp_wr.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_tx", exp_tx.size(), 0);
    chk("left_err", exp_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
